// File: rtl/wb_pkg.sv
// Shared encodings for the MEM/WB writeback select stage.
package wb_pkg;

    // Destination register select
    typedef enum logic [1:0] {
        REGDST_RT   = 2'b00,
        REGDST_RD   = 2'b01,
        REGDST_LINK = 2'b10,
        REGDST_RSVD = 2'b11
    } regdst_e;

    // Writeback data source indices
    localparam int unsigned SRC_ALU  = 0;
    localparam int unsigned SRC_MEM  = 1;
    localparam int unsigned SRC_LINK = 2;
    localparam int unsigned SRC_LUI  = 3;

    // Load access size; 2'b11 is treated as a word
    typedef enum logic [1:0] {
        LD_WORD = 2'b00,
        LD_HALF = 2'b01,
        LD_BYTE = 2'b10
    } ld_size_e;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load extractor: picks byte/half at the load offset and extends it.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic [1:0]        ld_off,
    output logic [DATA_W-1:0] ext_data
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Lane pick; halfwords are aligned on ld_off[1]
    always_comb begin
        byte_c = mem_data[{ld_off, 3'b000} +: 8];
        half_c = mem_data[{ld_off[1], 4'b0000} +: 16];
    end

    // Size-dependent sign/zero extension
    always_comb begin
        ext_data = mem_data;
        case (ld_size)
            LD_BYTE: ext_data = {{(DATA_W-8){ld_signed & byte_c[7]}}, byte_c};
            LD_HALF: ext_data = {{(DATA_W-16){ld_signed & half_c[15]}}, half_c};
            default: ext_data = mem_data;
        endcase
    end

endmodule

// File: rtl/wb_select_stage.sv
// MEM/WB writeback stage: selects destination and data, registers them for
// one cycle, and exposes forwarding hits and a retired-write counter.
// Optional: define WB_LOAD_EXT_EN to route source 1 through wb_load_ext.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned SEL_W    = $clog2(NUM_SRC),
    parameter int unsigned LINK_REG = 31
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      reg_write,
    input  logic [1:0]                reg_dst,
    input  logic [REG_AW-1:0]         rt_addr,
    input  logic [REG_AW-1:0]         rd_addr,
    input  logic [SEL_W-1:0]          data_sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [1:0]                ld_size,
    input  logic                      ld_signed,
    input  logic [1:0]                ld_off,
    input  logic [REG_AW-1:0]         qa_addr,
    input  logic [REG_AW-1:0]         qb_addr,
    output logic                      wb_valid,
    output logic                      wb_we,
    output logic [REG_AW-1:0]         wb_addr,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      fwd_a_hit,
    output logic                      fwd_b_hit,
    output logic                      illegal_sel,
    output logic [31:0]               retire_cnt
);

    localparam int unsigned CNT_W = 32;

    logic [DATA_W-1:0] mem_data_c;
    logic [DATA_W-1:0] sel_data_c;
    logic              sel_ok_c;
    logic [REG_AW-1:0] dest_c;
    logic              dst_ok_c;
    logic              legal_c;
    logic              we_next_c;
    logic              commit_c;

`ifdef WB_LOAD_EXT_EN
    wb_load_ext #(
        .DATA_W(DATA_W)
    ) u_load_ext (
        .mem_data (src_data[SRC_MEM*DATA_W +: DATA_W]),
        .ld_size  (ld_size),
        .ld_signed(ld_signed),
        .ld_off   (ld_off),
        .ext_data (mem_data_c)
    );
`else
    logic unused_ld;
    assign mem_data_c = src_data[SRC_MEM*DATA_W +: DATA_W];
    assign unused_ld  = ^{ld_size, ld_signed, ld_off};
`endif

    // Source mux; an out-of-range select yields zero data and flags illegal
    always_comb begin
        sel_data_c = '0;
        sel_ok_c   = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (data_sel == SEL_W'(i)) begin
                sel_ok_c   = 1'b1;
                sel_data_c = (i == SRC_MEM) ? mem_data_c : src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Destination decode; the reserved encoding targets r0 so nothing is written
    always_comb begin
        dest_c   = '0;
        dst_ok_c = 1'b1;
        case (reg_dst)
            REGDST_RT:   dest_c = rt_addr;
            REGDST_RD:   dest_c = rd_addr;
            REGDST_LINK: dest_c = REG_AW'(LINK_REG);
            default: begin
                dest_c   = '0;
                dst_ok_c = 1'b0;
            end
        endcase
    end

    assign legal_c   = sel_ok_c & dst_ok_c;
    assign we_next_c = in_valid & reg_write & (dest_c != '0) & legal_c;
    assign commit_c  = wb_we & ~stall & ~flush;

    // Stage register: rst > flush > stall > load
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            illegal_sel <= 1'b0;
        end else if (flush) begin
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            illegal_sel <= 1'b0;
        end else if (!stall) begin
            wb_valid    <= in_valid;
            wb_we       <= we_next_c;
            wb_addr     <= dest_c;
            wb_data     <= sel_data_c;
            illegal_sel <= in_valid & ~legal_c;
        end
    end

    // Retired-write counter: a held write commits when the stage advances
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (commit_c) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    assign fwd_a_hit = wb_we && (wb_addr == qa_addr) && (wb_addr != '0);
    assign fwd_b_hit = wb_we && (wb_addr == qb_addr) && (wb_addr != '0);

endmodule
